// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register.
// Carries a payload plus a valid bit between two pipeline stages. It honours
// the pipe_ctrl stall vector (hold vs. bubble insertion) and the interrupt
// flush. Saturating bubble/flush event counters feed the performance CSRs.
module pipe_stage_reg #(
  parameter int                 DATA_W     = 32,
  parameter int                 STALL_W    = 6,
  parameter int                 STAGE      = 2,
  parameter logic [DATA_W-1:0]  CLEAR_MASK = {DATA_W{1'b1}},
  parameter logic [DATA_W-1:0]  RESET_VAL  = {DATA_W{1'b0}},
  parameter int                 CNT_W      = 16
) (
  input  logic               clk_in,
  input  logic               reset_n_in,
  input  logic               valid_in,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [STALL_W-1:0] stall_in,
  input  logic               flush_in,
  input  logic               cnt_clr_in,
  output logic               valid_out,
  output logic [DATA_W-1:0]  data_out,
  output logic [CNT_W-1:0]   bubble_cnt_out,
  output logic [CNT_W-1:0]   flush_cnt_out
);

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_FLUSH,
    ACT_HOLD,
    ACT_BUBBLE
  } action_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              stall_up;
  logic              stall_dn;
  action_e           action;
  logic [DATA_W-1:0] data_cleared;
  logic              bubble_inc;
  logic              flush_inc;

  assign stall_up = stall_in[STAGE];

  // The last stage has no downstream stall bit; it can never be held, only bubbled.
  generate
    if (STAGE + 1 < STALL_W) begin : g_has_dn
      assign stall_dn = stall_in[STAGE+1];
    end else begin : g_no_dn
      assign stall_dn = 1'b0;
    end
  endgenerate

  // Stall bits belonging to other stages are intentionally ignored here.
  logic unused_stall;
  assign unused_stall = ^stall_in;

  // Only the CLEAR_MASK bits take RESET_VAL on a flush/bubble; the rest keep their value.
  assign data_cleared = (data_out & ~CLEAR_MASK) | (RESET_VAL & CLEAR_MASK);

  // Decode the per-edge action in strict priority order: flush, hold, bubble, advance.
  // The illegal stall_up=0/stall_dn=1 combination falls through to ADVANCE.
  always_comb begin
    // NOTE: default assignment first so every path drives action and no latch is inferred.
    action = ACT_ADVANCE;
    if (flush_in) begin
      action = ACT_FLUSH;
    end else if (stall_up && stall_dn) begin
      action = ACT_HOLD;
    end else if (stall_up) begin
      action = ACT_BUBBLE;
    end
  end

  assign bubble_inc = (action == ACT_BUBBLE);
  assign flush_inc  = (action == ACT_FLUSH) && (valid_out || valid_in);

  // Payload path: valid bit and data register.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      valid_out <= 1'b0;
      data_out  <= RESET_VAL;
    end else begin
      case (action)
        ACT_FLUSH, ACT_BUBBLE: begin
          valid_out <= 1'b0;
          data_out  <= data_cleared;
        end
        ACT_HOLD: begin
          valid_out <= valid_out;
          data_out  <= data_out;
        end
        default: begin
          valid_out <= valid_in;
          data_out  <= data_in;
        end
      endcase
    end
  end

  // Bubble counter: saturating, synchronous clear overrides a same-edge increment.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      bubble_cnt_out <= '0;
    end else if (cnt_clr_in) begin
      bubble_cnt_out <= '0;
    end else if (bubble_inc && (bubble_cnt_out != CNT_MAX)) begin
      bubble_cnt_out <= bubble_cnt_out + 1'b1;
    end
  end

  // Flush counter: counts only flushes that killed a valid entry; same clear/saturation rules.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      flush_cnt_out <= '0;
    end else if (cnt_clr_in) begin
      flush_cnt_out <= '0;
    end else if (flush_inc && (flush_cnt_out != CNT_MAX)) begin
      flush_cnt_out <= flush_cnt_out + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: three instances (default, partial-clear with
// 2-bit counters, last stage) share the stimulus; each phase resets them and
// checks one instance against expected values queued as stimulus is driven.
module tb_pipe_stage_reg;

  logic        clk_in;
  logic        reset_n_in;
  logic        valid_in;
  logic [31:0] data_in;
  logic [5:0]  stall_in;
  logic        flush_in;
  logic        cnt_clr_in;

  logic        a_valid, b_valid, c_valid;
  logic [31:0] a_data, b_data, c_data;
  logic [15:0] a_bcnt, a_fcnt, c_bcnt, c_fcnt;
  logic [1:0]  b_bcnt, b_fcnt;

  int checks = 0;
  int errors = 0;
  int step   = 0;

  typedef struct {
    int          sel;
    logic        v;
    logic [31:0] d;
    logic [5:0]  st;
    logic        fl;
    logic        clr;
    logic        ev;
    logic [31:0] ed;
    logic [15:0] eb;
    logic [15:0] ef;
  } vec_t;

  vec_t exp_q[$];

  pipe_stage_reg u_dut_a (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .valid_in(valid_in), .data_in(data_in),
    .stall_in(stall_in), .flush_in(flush_in), .cnt_clr_in(cnt_clr_in),
    .valid_out(a_valid), .data_out(a_data), .bubble_cnt_out(a_bcnt), .flush_cnt_out(a_fcnt)
  );

  pipe_stage_reg #(.CLEAR_MASK(32'h0000_00FF), .RESET_VAL(32'h0), .CNT_W(2)) u_dut_b (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .valid_in(valid_in), .data_in(data_in),
    .stall_in(stall_in), .flush_in(flush_in), .cnt_clr_in(cnt_clr_in),
    .valid_out(b_valid), .data_out(b_data), .bubble_cnt_out(b_bcnt), .flush_cnt_out(b_fcnt)
  );

  pipe_stage_reg #(.STAGE(5)) u_dut_c (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .valid_in(valid_in), .data_in(data_in),
    .stall_in(stall_in), .flush_in(flush_in), .cnt_clr_in(cnt_clr_in),
    .valid_out(c_valid), .data_out(c_data), .bubble_cnt_out(c_bcnt), .flush_cnt_out(c_fcnt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // pipe_ctrl never drives upstream-running with downstream-stalled for stage 2.
  always @(posedge clk_in) begin
    if (reset_n_in) begin
      assert (!(!stall_in[2] && stall_in[3]))
        else $error("illegal stall combination stall_in=%b", stall_in);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int sel, input logic v, input logic [31:0] d,
                              input logic [5:0] st, input logic fl, input logic clr,
                              input logic ev, input logic [31:0] ed,
                              input logic [15:0] eb, input logic [15:0] ef);
    vec_t r;
    r.sel = sel; r.v = v; r.d = d; r.st = st; r.fl = fl; r.clr = clr;
    r.ev = ev; r.ed = ed; r.eb = eb; r.ef = ef;
    return r;
  endfunction

  task automatic compare_outputs(input string tag, input int sel, input logic ev,
                                 input logic [31:0] ed, input logic [15:0] eb,
                                 input logic [15:0] ef);
    logic        av;
    logic [31:0] ad;
    logic [15:0] ab, af;
    case (sel)
      0:       begin av = a_valid; ad = a_data; ab = a_bcnt; af = a_fcnt; end
      1:       begin av = b_valid; ad = b_data; ab = {14'd0, b_bcnt}; af = {14'd0, b_fcnt}; end
      default: begin av = c_valid; ad = c_data; ab = c_bcnt; af = c_fcnt; end
    endcase
    check($sformatf("%s_valid", tag), {31'd0, av}, {31'd0, ev});
    check($sformatf("%s_data", tag), ad, ed);
    check($sformatf("%s_bubble_cnt", tag), {16'd0, ab}, {16'd0, eb});
    check($sformatf("%s_flush_cnt", tag), {16'd0, af}, {16'd0, ef});
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare just after the edge.
  task automatic apply(input vec_t v);
    vec_t e;
    valid_in   = v.v;
    data_in    = v.d;
    stall_in   = v.st;
    flush_in   = v.fl;
    cnt_clr_in = v.clr;
    exp_q.push_back(v);
    @(posedge clk_in);
    #1;
    e = exp_q.pop_front();
    step++;
    compare_outputs($sformatf("s%0d_dut%0d", step, e.sel), e.sel, e.ev, e.ed, e.eb, e.ef);
  endtask

  task automatic do_reset(input int sel);
    valid_in   = 1'b0;
    data_in    = '0;
    stall_in   = '0;
    flush_in   = 1'b0;
    cnt_clr_in = 1'b0;
    reset_n_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    reset_n_in = 1'b1;
    compare_outputs($sformatf("reset_dut%0d", sel), sel, 1'b0, 32'h0, 16'd0, 16'd0);
  endtask

  vec_t tbl[$];

  initial begin
    reset_n_in = 1'b0;
    valid_in   = 1'b0;
    data_in    = '0;
    stall_in   = '0;
    flush_in   = 1'b0;
    cnt_clr_in = 1'b0;

    // Default instance: load, then reset asynchronously in the middle of a cycle.
    do_reset(0);
    apply(mk(0, 1'b1, 32'h0BAD_F00D, 6'b000000, 1'b0, 1'b0, 1'b1, 32'h0BAD_F00D, 16'd0, 16'd0));
    apply(mk(0, 1'b0, 32'h0, 6'b000100, 1'b0, 1'b0, 1'b0, 32'h0, 16'd1, 16'd0));
    #2;
    reset_n_in = 1'b0;
    #1;
    compare_outputs("async_reset", 0, 1'b0, 32'h0, 16'd0, 16'd0);
    #1;
    reset_n_in = 1'b1;

    tbl.push_back(mk(0, 1'b1, 32'hDEAD_BEEF, 6'b000000, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 16'd0, 16'd0));
    tbl.push_back(mk(0, 1'b1, 32'h1234_5678, 6'b000000, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 16'd0, 16'd0));
    tbl.push_back(mk(0, 1'b0, 32'hFFFF_FFFF, 6'b001100, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 16'd0, 16'd0));
    tbl.push_back(mk(0, 1'b0, 32'hFFFF_FFFF, 6'b001100, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 16'd0, 16'd0));
    tbl.push_back(mk(0, 1'b0, 32'hFFFF_FFFF, 6'b001100, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 16'd0, 16'd0));
    tbl.push_back(mk(0, 1'b1, 32'hFFFF_FFFF, 6'b000100, 1'b0, 1'b0, 1'b0, 32'h0,         16'd1, 16'd0));
    tbl.push_back(mk(0, 1'b1, 32'hFFFF_FFFF, 6'b000100, 1'b0, 1'b0, 1'b0, 32'h0,         16'd2, 16'd0));
    tbl.push_back(mk(0, 1'b1, 32'hCAFE_F00D, 6'b000000, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 16'd2, 16'd0));
    // Flush beats hold, then back-to-back flushes with and without a valid input.
    tbl.push_back(mk(0, 1'b0, 32'h0000_1111, 6'b001100, 1'b1, 1'b0, 1'b0, 32'h0,         16'd2, 16'd1));
    tbl.push_back(mk(0, 1'b0, 32'h0000_1111, 6'b000000, 1'b1, 1'b0, 1'b0, 32'h0,         16'd2, 16'd1));
    tbl.push_back(mk(0, 1'b1, 32'h0000_2222, 6'b000000, 1'b1, 1'b0, 1'b0, 32'h0,         16'd2, 16'd2));
    tbl.push_back(mk(0, 1'b1, 32'hA5A5_A5A5, 6'b000000, 1'b0, 1'b0, 1'b1, 32'hA5A5_A5A5, 16'd2, 16'd2));
    // Counter clear overrides a same-edge bubble increment; payload still bubbles.
    tbl.push_back(mk(0, 1'b1, 32'h0,         6'b000100, 1'b0, 1'b1, 1'b0, 32'h0,         16'd0, 16'd0));
    tbl.push_back(mk(0, 1'b0, 32'h0000_0077, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0000_0077, 16'd0, 16'd0));
    tbl.push_back(mk(0, 1'b0, 32'h0,         6'b000100, 1'b0, 1'b0, 1'b0, 32'h0,         16'd1, 16'd0));
    // Stall bits of other stages do not affect this stage.
    tbl.push_back(mk(0, 1'b1, 32'h1357_9BDF, 6'b100001, 1'b0, 1'b0, 1'b1, 32'h1357_9BDF, 16'd1, 16'd0));
    foreach (tbl[i]) apply(tbl[i]);

    // Partial clear (low byte only) with 2-bit saturating counters.
    do_reset(1);
    apply(mk(1, 1'b1, 32'hAABB_CCDD, 6'b000000, 1'b0, 1'b0, 1'b1, 32'hAABB_CCDD, 16'd0, 16'd1 - 16'd1));
    apply(mk(1, 1'b0, 32'h0, 6'b001100, 1'b1, 1'b0, 1'b0, 32'hAABB_CC00, 16'd0, 16'd1));
    apply(mk(1, 1'b0, 32'h0, 6'b000000, 1'b1, 1'b0, 1'b0, 32'hAABB_CC00, 16'd0, 16'd1));
    for (int k = 1; k <= 5; k++) begin
      apply(mk(1, 1'b0, 32'h0, 6'b000100, 1'b0, 1'b0, 1'b0, 32'hAABB_CC00,
               (k > 3) ? 16'd3 : 16'(k), 16'd1));
    end
    apply(mk(1, 1'b0, 32'h0, 6'b000100, 1'b0, 1'b1, 1'b0, 32'hAABB_CC00, 16'd0, 16'd0));

    // Last stage: no downstream stall bit, so stall_up always means bubble.
    do_reset(2);
    apply(mk(2, 1'b1, 32'h0000_0055, 6'b000000, 1'b0, 1'b0, 1'b1, 32'h0000_0055, 16'd0, 16'd0));
    apply(mk(2, 1'b1, 32'h0000_0066, 6'b100000, 1'b0, 1'b0, 1'b0, 32'h0,         16'd1, 16'd0));
    apply(mk(2, 1'b1, 32'h0000_0077, 6'b100000, 1'b0, 1'b0, 1'b0, 32'h0,         16'd2, 16'd0));
    apply(mk(2, 1'b1, 32'h0000_0088, 6'b111111, 1'b0, 1'b0, 1'b0, 32'h0,         16'd3, 16'd0));
    apply(mk(2, 1'b1, 32'h0000_0099, 6'b001100, 1'b0, 1'b0, 1'b1, 32'h0000_0099, 16'd3, 16'd0));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
